search_multi: RTL and testbench
===============================

SEARCH_MULTI -- requirements
Module: search_multi

Interface
REQ-001 Parameter ADDR_W, default 8, address and length width for pattern and block memories.
REQ-002 Parameter DATA_W, default 8, width of one pattern and memory element.
REQ-003 Parameter WILDCARD, default 8'h3F (DATA_W bits), pattern value that matches any element when wildcard support is compiled in.
REQ-004 CLK100MHZ  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 p  input  ADDR_W  start address of the pattern in pattern memory.
REQ-007 pl  input  ADDR_W  pattern length in elements.
REQ-008 b  input  ADDR_W  start address of the block to search.
REQ-009 bl  input  ADDR_W  block length in elements.
REQ-010 start  input  1  pulse; latch p/pl/b/bl and search from b.
REQ-011 activate  input  1  pulse; resume the search from found+1 after a hit.
REQ-012 pat_addr  output  ADDR_W  pattern memory read address, registered.
REQ-013 pat_data  input  DATA_W  pattern memory read data, valid one cycle after pat_addr.
REQ-014 mem_addr  output  ADDR_W  block memory read address, registered.
REQ-015 mem_data  input  DATA_W  block memory read data, valid one cycle after mem_addr.
REQ-016 busy  output  1  high in FETCH and COMPARE.
REQ-017 hit  output  1  high while in MATCH.
REQ-018 done  output  1  high while in DONE (window exhausted).
REQ-019 found  output  ADDR_W  start address of the most recent match.
REQ-020 match_count  output  ADDR_W+1  matches found since the last start.

Function
REQ-021 The block SHALL implement states IDLE, FETCH, COMPARE, MATCH, DONE.
REQ-022 IDLE/DONE + start: latch inputs, candidate s=b, index i=0, match_count=0, go to FETCH; when pl==0 or pl>bl, go to DONE directly.
REQ-023 FETCH SHALL drive pat_addr=p+i and mem_addr=s+i (mod 2^ADDR_W) and go to COMPARE next cycle.
REQ-024 COMPARE equal and i<pl-1: i+=1, go to FETCH.
REQ-025 COMPARE equal and i==pl-1: found=s, match_count+=1, go to MATCH.
REQ-026 COMPARE mismatch: i=0, s+=1, go to FETCH; if s was the last candidate, go to DONE.
REQ-027 The last candidate SHALL be min(b+bl-pl, 2^ADDR_W-pl), computed in ADDR_W+1 bits; candidates never wrap past address 2^ADDR_W-1.
REQ-028 MATCH + activate: s=found+1, i=0, go to FETCH; if found was the last candidate, go to DONE.
REQ-029 MATCH + start SHALL behave as REQ-022; start takes priority over activate when both are high.
REQ-030 start and activate SHALL be ignored in FETCH/COMPARE; activate SHALL be ignored in IDLE/DONE.
REQ-031 Latency: a match at s=b SHALL raise hit exactly 2*pl cycles after the edge that samples start.
REQ-032 found and match_count SHALL hold their values in DONE and IDLE until the next start.
REQ-033 match_count SHALL saturate at its maximum value.

Reset
REQ-034 reset low at a rising edge SHALL force IDLE, including mid-search.
REQ-035 Reset values: busy=0, hit=0, done=0, found=0, match_count=0, pat_addr=0, mem_addr=0.

Configuration
REQ-036 Macro SEARCH_WILDCARD_EN defined: a pattern element equal to WILDCARD SHALL compare equal to any mem_data.
REQ-037 Macro SEARCH_WILDCARD_EN undefined: comparison SHALL be exact equality only, and WILDCARD SHALL be unused.

Verification
REQ-038 mem[0..19]=01 02 03 01 02 05..., pattern 01 02, p=0 pl=2 b=0 bl=20, start -> hit at cycle 4, found=0, match_count=1.
REQ-039 Continuing REQ-038, activate -> found=3, match_count=2; activate again -> done=1 with found=3 held.
REQ-040 pl=0, then pl=21 with bl=20 -> done one cycle after start, hit never asserted, match_count=0.
REQ-041 b=8'hFE bl=10 pl=2 -> mem_addr never exceeds 8'hFF and the last candidate checked is 8'hFE.
REQ-042 reset low during COMPARE -> IDLE next cycle with all outputs at reset values; a new start searches correctly.
REQ-043 SEARCH_WILDCARD_EN defined, pattern 01 3F, mem 01 77 -> hit, found=0; SEARCH_WILDCARD_EN undefined -> no hit.

Source files
------------

// File: rtl/search_multi.sv
// Multi-match pattern search over a block memory. Optional wildcard compare is
// compiled in with SEARCH_WILDCARD_EN.
module search_multi #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter logic [DATA_W-1:0] WILDCARD = DATA_W'(8'h3F)
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p,
    input  logic [ADDR_W-1:0] pl,
    input  logic [ADDR_W-1:0] b,
    input  logic [ADDR_W-1:0] bl,
    input  logic              start,
    input  logic              activate,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [DATA_W-1:0] pat_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              hit,
    output logic              done,
    output logic [ADDR_W-1:0] found,
    output logic [ADDR_W:0]   match_count
);

    typedef enum logic [2:0] {StIdle, StFetch, StCompare, StMatch, StDone} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] p_q, p_d, pl_q, pl_d, s_q, s_d, i_q, i_d;
    logic [ADDR_W-1:0] found_q, found_d, pat_addr_q, pat_addr_d, mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   last_q, last_d, cnt_q, cnt_d;
    logic [ADDR_W:0]   block_end, addr_end, last_calc;
    logic              start_ok, launch, eq;

    // Last candidate is clipped so a window never runs past the top of memory.
    assign block_end = {1'b0, b} + {1'b0, bl} - {1'b0, pl};
    assign addr_end  = {1'b1, {ADDR_W{1'b0}}} - {1'b0, pl};
    assign last_calc = (block_end < addr_end) ? block_end : addr_end;
    assign start_ok  = (pl != '0) && (pl <= bl) && ({1'b0, b} <= last_calc);

`ifdef SEARCH_WILDCARD_EN
    assign eq = (pat_data == mem_data) || (pat_data == WILDCARD);
`else
    logic unused_wildcard;
    assign unused_wildcard = ^WILDCARD;
    assign eq = (pat_data == mem_data);
`endif

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        pl_d       = pl_q;
        s_d        = s_q;
        i_d        = i_q;
        last_d     = last_q;
        found_d    = found_q;
        cnt_d      = cnt_q;
        pat_addr_d = pat_addr_q;
        mem_addr_d = mem_addr_q;
        launch     = 1'b0;

        unique case (state_q)
            StIdle, StDone: launch = start;
            StFetch: state_d = StCompare;
            StCompare: begin
                if (eq) begin
                    if (i_q == pl_q - ADDR_W'(1)) begin
                        found_d = s_q;
                        if (cnt_q != '1) cnt_d = cnt_q + (ADDR_W+1)'(1);
                        state_d = StMatch;
                    end else begin
                        i_d        = i_q + ADDR_W'(1);
                        pat_addr_d = p_q + i_q + ADDR_W'(1);
                        mem_addr_d = s_q + i_q + ADDR_W'(1);
                        state_d    = StFetch;
                    end
                end else if ({1'b0, s_q} == last_q) begin
                    state_d = StDone;
                end else begin
                    s_d        = s_q + ADDR_W'(1);
                    i_d        = '0;
                    pat_addr_d = p_q;
                    mem_addr_d = s_q + ADDR_W'(1);
                    state_d    = StFetch;
                end
            end
            StMatch: begin
                if (start) begin
                    launch = 1'b1;
                end else if (activate) begin
                    if ({1'b0, found_q} == last_q) begin
                        state_d = StDone;
                    end else begin
                        s_d        = found_q + ADDR_W'(1);
                        i_d        = '0;
                        pat_addr_d = p_q;
                        mem_addr_d = found_q + ADDR_W'(1);
                        state_d    = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            p_d        = p;
            pl_d       = pl;
            last_d     = last_calc;
            s_d        = b;
            i_d        = '0;
            cnt_d      = '0;
            pat_addr_d = p;
            mem_addr_d = b;
            state_d    = start_ok ? StFetch : StDone;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state_q    <= StIdle;
            p_q        <= '0;
            pl_q       <= '0;
            s_q        <= '0;
            i_q        <= '0;
            last_q     <= '0;
            found_q    <= '0;
            cnt_q      <= '0;
            pat_addr_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            pl_q       <= pl_d;
            s_q        <= s_d;
            i_q        <= i_d;
            last_q     <= last_d;
            found_q    <= found_d;
            cnt_q      <= cnt_d;
            pat_addr_q <= pat_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy        = (state_q == StFetch) || (state_q == StCompare);
    assign hit         = (state_q == StMatch);
    assign done        = (state_q == StDone);
    assign found       = found_q;
    assign match_count = cnt_q;
    assign pat_addr    = pat_addr_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_search_multi.sv
// Directed bench for search_multi with registered-read pattern and block memories.
module tb_search_multi;

    logic       clk = 1'b0;
    logic       reset, start, activate;
    logic [7:0] p, pl, b, bl;
    logic [7:0] pat_addr, mem_addr, pat_data, mem_data, found;
    logic       busy, hit, done;
    logic [8:0] match_count;

    logic [7:0] pmem [256];
    logic [7:0] bmem [256];

    int  total = 0;
    int  passed = 0;
    bit  ok;
    logic watch = 1'b0;
    logic low_seen, hit_seen;

    always #5 clk = ~clk;

    search_multi dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .p           (p),
        .pl          (pl),
        .b           (b),
        .bl          (bl),
        .start       (start),
        .activate    (activate),
        .pat_addr    (pat_addr),
        .pat_data    (pat_data),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy),
        .hit         (hit),
        .done        (done),
        .found       (found),
        .match_count (match_count)
    );

    always @(posedge clk) begin
        pat_data <= pmem[pat_addr];
        mem_data <= bmem[mem_addr];
    end

    always @(posedge clk) begin
        if (!watch) begin
            low_seen <= 1'b0;
            hit_seen <= 1'b0;
        end else begin
            if (busy && mem_addr < 8'hFE) low_seen <= 1'b1;
            if (hit) hit_seen <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic launch(input logic [7:0] np, input logic [7:0] npl,
                          input logic [7:0] nb, input logic [7:0] nbl);
        p = np; pl = npl; b = nb; bl = nbl;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_act();
        activate = 1'b1;
        tick();
        activate = 1'b0;
    endtask

    task automatic wait_ev(output bit got);
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (hit || done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            pmem[k] = 8'h00;
            bmem[k] = 8'hEE;
        end
        pmem[0] = 8'h01; pmem[1] = 8'h02;
        pmem[10] = 8'h01; pmem[11] = 8'h3F;
        bmem[0] = 8'h01; bmem[1] = 8'h02; bmem[2] = 8'h03;
        bmem[3] = 8'h01; bmem[4] = 8'h02;
        for (int k = 5; k < 20; k++) bmem[k] = 8'(k);
        bmem[40] = 8'h01; bmem[41] = 8'h77;

        reset = 1'b0; start = 1'b0; activate = 1'b0;
        p = '0; pl = '0; b = '0; bl = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        chk("rst_addrs", {16'd0, pat_addr, mem_addr}, 32'd0);
        reset = 1'b1;
        tick();

        // First match at b, latency 2*pl
        launch(8'd0, 8'd2, 8'd0, 8'd20);
        chk("fetch_busy", 32'(busy), 32'd1);
        tick(); tick(); tick();
        chk("hit_early", 32'(hit), 32'd0);
        tick();
        chk("hit_lat4", 32'(hit), 32'd1);
        chk("found0", 32'(found), 32'd0);
        chk("count1", 32'(match_count), 32'd1);

        pulse_act();
        wait_ev(ok);
        chk("wait2", 32'(ok), 32'd1);
        chk("hit2", 32'(hit), 32'd1);
        chk("found3", 32'(found), 32'd3);
        chk("count2", 32'(match_count), 32'd2);

        pulse_act();
        wait_ev(ok);
        chk("wait3", 32'(ok), 32'd1);
        chk("done_end", 32'(done), 32'd1);
        chk("found_held", 32'(found), 32'd3);
        chk("count_held", 32'(match_count), 32'd2);
        pulse_act();
        chk("act_ign_done", {31'd0, done}, 32'd1);

        // Degenerate lengths go straight to DONE
        watch = 1'b1;
        launch(8'd0, 8'd0, 8'd0, 8'd20);
        chk("pl0_done", 32'(done), 32'd1);
        chk("pl0_count", 32'(match_count), 32'd0);
        launch(8'd0, 8'd21, 8'd0, 8'd20);
        chk("pllong_done", 32'(done), 32'd1);
        tick();
        chk("degen_nohit", 32'(hit_seen), 32'd0);
        watch = 1'b0;
        tick();

        // Top-of-memory window: only candidate 0xFE
        bmem[8'hFE] = 8'h01; bmem[8'hFF] = 8'h02;
        watch = 1'b1;
        launch(8'd0, 8'd2, 8'hFE, 8'd10);
        wait_ev(ok);
        chk("top_hit", {31'd0, hit}, 32'd1);
        chk("top_found", 32'(found), 32'hFE);
        pulse_act();
        chk("top_done", 32'(done), 32'd1);
        chk("top_nowrap", 32'(low_seen), 32'd0);
        watch = 1'b0;
        tick();
        bmem[8'hFF] = 8'h09;
        watch = 1'b1;
        launch(8'd0, 8'd2, 8'hFE, 8'd10);
        wait_ev(ok);
        chk("top_miss_done", 32'(done), 32'd1);
        chk("top_miss_count", 32'(match_count), 32'd0);
        chk("top_miss_nohit", 32'(hit_seen), 32'd0);
        chk("top_miss_nowrap", 32'(low_seen), 32'd0);
        watch = 1'b0;
        tick();

        // Reset during COMPARE, then a clean search
        launch(8'd0, 8'd2, 8'd0, 8'd20);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_flags", {29'd0, busy, hit, done}, 32'd0);
        chk("mid_rst_vals", {7'd0, match_count, found, pat_addr}, 32'd0);
        chk("mid_rst_maddr", 32'(mem_addr), 32'd0);
        reset = 1'b1;
        tick();
        launch(8'd0, 8'd2, 8'd0, 8'd20);
        tick(); tick(); tick(); tick();
        chk("post_rst_hit", 32'(hit), 32'd1);
        chk("post_rst_found", 32'(found), 32'd0);
        pulse_act();
        wait_ev(ok);
        chk("pre_prio_found", 32'(found), 32'd3);

        // start wins over activate in MATCH
        start = 1'b1; activate = 1'b1;
        tick();
        start = 1'b0; activate = 1'b0;
        wait_ev(ok);
        chk("prio_found", 32'(found), 32'd0);
        chk("prio_count", 32'(match_count), 32'd1);

        // Wildcard pattern 01 3F against 01 77
        launch(8'd10, 8'd2, 8'd40, 8'd2);
        chk("wc_addrs", {16'd0, pat_addr, mem_addr}, {16'd0, 8'd10, 8'd40});
        tick(); tick();
        chk("wc_addrs_i1", {16'd0, pat_addr, mem_addr}, {16'd0, 8'd11, 8'd41});
        wait_ev(ok);
`ifdef SEARCH_WILDCARD_EN
        chk("wc_hit", 32'(hit), 32'd1);
        chk("wc_found", 32'(found), 32'd40);
`else
        chk("wc_nohit", 32'(hit), 32'd0);
        chk("wc_done", 32'(done), 32'd1);
        chk("wc_count", 32'(match_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
